// File: rtl/alu_sequencer.sv
// Upstream control stage for the 8-bit ALU: holds a small instruction program,
// issues one instruction at a time, waits for alu_done and captures the result.
module alu_sequencer #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 32,
    parameter bit WRAP    = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [23:0]   prog_data,
    input  logic          start,
    input  logic          alu_done,
    input  logic [7:0]    alu_results,
    output logic [7:0]    a,
    output logic [7:0]    b,
    output logic [3:0]    op,
    output logic          acc,
    output logic          en,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted,
    output logic          error,
    output logic [7:0]    result,
    output logic          result_valid,
    output logic [7:0]    instr_count
);

    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_NEXT, S_HALTED, S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    a_q, a_d, b_q, b_d, result_q, result_d, instr_count_q, instr_count_d;
    logic [3:0]    op_q, op_d;
    logic          acc_q, acc_d, en_q, en_d, result_valid_q, result_valid_d;
    logic          armed_q, armed_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [WW-1:0] wd_q, wd_d;

    logic [23:0]   mem [DEPTH];
    logic [23:0]   instr;
    logic          idle_like;
    logic          reserved_unused;

    assign idle_like       = (state_q == S_IDLE) || (state_q == S_HALTED) || (state_q == S_ERROR);
    assign instr           = mem[pc_q];
    assign reserved_unused = ^instr[22:21];

    always_ff @(posedge clk) begin
        if (prog_we && idle_like) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        op_d           = op_q;
        acc_d          = acc_q;
        en_d           = en_q;
        pc_d           = pc_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        instr_count_d  = instr_count_q;
        armed_d        = armed_q;
        wd_d           = wd_q;
        case (state_q)
            S_IDLE, S_HALTED, S_ERROR: begin
                en_d = 1'b0;
                if (start) begin
                    pc_d          = '0;
                    instr_count_d = '0;
                    state_d       = S_FETCH;
                end
            end
            S_FETCH: begin
                if (instr[23]) begin
                    state_d = S_HALTED;
                end else begin
                    acc_d   = instr[20];
                    op_d    = instr[19:16];
                    a_d     = instr[15:8];
                    b_d     = instr[7:0];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                en_d    = 1'b1;
                armed_d = 1'b0;
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_q + WW'(1);
                // A done flag seen before any low sample belongs to the previous instruction
                if (!alu_done) begin
                    armed_d = 1'b1;
                end
                if (alu_done && armed_q) begin
                    result_d       = alu_results;
                    result_valid_d = 1'b1;
                    if (instr_count_q != '1) begin
                        instr_count_d = instr_count_q + 8'd1;
                    end
                    en_d    = 1'b0;
                    state_d = S_NEXT;
                end else if (wd_q == WW'(TIMEOUT - 1)) begin
                    en_d    = 1'b0;
                    state_d = S_ERROR;
                end
            end
            S_NEXT: begin
                if (pc_q != AW'(DEPTH - 1)) begin
                    pc_d    = pc_q + AW'(1);
                    state_d = S_FETCH;
                end else if (WRAP) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_HALTED;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= '0;
            acc_q          <= 1'b0;
            en_q           <= 1'b0;
            pc_q           <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            instr_count_q  <= '0;
            armed_q        <= 1'b0;
            wd_q           <= '0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            b_q            <= b_d;
            op_q           <= op_d;
            acc_q          <= acc_d;
            en_q           <= en_d;
            pc_q           <= pc_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            instr_count_q  <= instr_count_d;
            armed_q        <= armed_d;
            wd_q           <= wd_d;
        end
    end

    assign a            = a_q;
    assign b            = b_q;
    assign op           = op_q;
    assign acc          = acc_q;
    assign en           = en_q;
    assign pc           = pc_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign instr_count  = instr_count_q;
    assign busy         = (state_q == S_FETCH) || (state_q == S_ISSUE) ||
                          (state_q == S_WAIT)  || (state_q == S_NEXT);
    assign halted       = (state_q == S_HALTED);
    assign error        = (state_q == S_ERROR);

endmodule
